bf_hazard_ctrl: RTL
===================

Name: bf_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage MIPS pipeline registers: BF0 (IF/ID), BF1 (ID/EX) and the MEM stage behind them.
- Tracks the destination register of the instructions in EX and MEM.
- Generates stall, bubble and flush controls for the PC, BF0 and BF1, and registered ALU operand-forwarding selects aligned with the BF1 contents.
- Sequences multi-cycle ALU ops (MULT/DIV) by freezing the front of the pipeline for a fixed latency.

Parameters:
MUL_LAT, 4, total EX cycles of a multi-cycle op; legal values are 2 to 15.
RW, 5, register index width.

Ports:
clk_HC  input  1  pipeline clock.
rst_HC  input  1  asynchronous, active-high reset.
idValid  input  1  ID stage holds a real instruction.
idRs  input  RW  rs index of the ID instruction.
idRt  input  RW  rt index of the ID instruction.
idUsesRs  input  1  ID instruction reads rs.
idUsesRt  input  1  ID instruction reads rt.
idRd  input  RW  destination index of the ID instruction (same value presented to BF1 rd).
idRegWrite  input  1  ID instruction writes idRd.
idMemRead  input  1  ID instruction is a load.
idMulti  input  1  ID instruction is a multi-cycle ALU op.
brTaken  input  1  branch/jump resolved taken in EX this cycle.
enPC  output  1  PC load enable.
enBF0  output  1  BF0 load enable.
enBF1  output  1  BF1 load enable (0 = hold).
flushBF0  output  1  clear BF0 to NOP.
bubbleBF1  output  1  load NOP into BF1 instead of ID contents.
fwdA  output  2  ALU operand A source: 00 reg file, 01 EX result, 10 MEM result.
fwdB  output  2  operand B source, same encoding.
busy  output  1  multi-cycle op in progress.

Behaviour:
- Stage records: EXrec = {valid, rd, regWrite, memRead} and MEMrec = {valid, rd, regWrite}, both updated at the posedge.
  - If enBF1 = 1: EXrec takes the ID fields, or all-zero if bubbleBF1 = 1. MEMrec takes the old EXrec.
  - If enBF1 = 0: EXrec holds. MEMrec takes all-zero, because MEM receives a bubble.
- Match definition: match(r, rec) is true when rec.valid, rec.regWrite, rec.rd != 0 and rec.rd == r. Register 0 never matches.
- States:
  - RUN.
  - MULTI, with down-counter cnt of 4 bits.
- Load-use condition (LU): idValid, EXrec.memRead, and either (idUsesRs and match(idRs, EXrec)) or (idUsesRt and match(idRt, EXrec)).
- Output and transition rules, in priority order:
  1. rst_HC high: state = RUN; cnt = 0; both records cleared; fwdA = fwdB = 00; enPC = enBF0 = enBF1 = 0; flushBF0 = 1; bubbleBF1 = 1; busy = 0.
  2. MULTI: enPC = enBF0 = enBF1 = 0; busy = 1; flushBF0 = bubbleBF1 = 0; brTaken is ignored. cnt decrements each cycle. When cnt == 1, the next state is RUN.
  3. RUN with brTaken: enPC = 1, enBF0 = 1, flushBF0 = 1, enBF1 = 1, bubbleBF1 = 1. brTaken overrides LU and idMulti.
  4. RUN with LU: enPC = 0, enBF0 = 0, enBF1 = 1, bubbleBF1 = 1. This is a one-cycle stall; the same instruction is re-evaluated next cycle.
  5. RUN otherwise: all enables 1; flush and bubble 0. If idValid and idMulti, the op enters BF1, and the next state is MULTI with cnt = MUL_LAT-1.
- Forwarding: registered, updated only when enBF1 = 1 and bubbleBF1 = 0; otherwise fwdA and fwdB hold (a bubble forces 00).
  - The next fwdA value is computed from the pre-edge records:
    - 01 if idUsesRs and match(idRs, EXrec) and not EXrec.memRead.
    - else 10 if idUsesRs and match(idRs, MEMrec).
    - else 00.
  - EX priority beats MEM when both match. fwdB is the same with rt.
  - A load in EX never produces 01; LU covers that case.
- Latency: control outputs are combinational from state, records and inputs in the same cycle. fwdA/fwdB are valid in the cycle the instruction sits in BF1.
- Reset mid-MULTI aborts the op immediately: state = RUN, cnt = 0, busy = 0 asynchronously.

Test Plan:
- Load-use: lw $8 in EX, ID add reads rs = 8 (idUsesRs = 1) -> one cycle with enPC = 0, enBF0 = 0, bubbleBF1 = 1. The next cycle runs freely, and that add enters BF1 with fwdA = 10.
- Double match: EX and MEM both write $5 (non-load), ID reads rs = 5 and rt = 5 -> fwdA = 01 and fwdB = 01. Repeat with only MEM writing $5 -> 10 and 10.
- Register zero: EX writes rd = 0 with regWrite = 1, ID reads rs = 0 -> fwdA = 00 and no stall, even when EXrec.memRead = 1.
- Multi-cycle, MUL_LAT = 4: idMulti accepted -> busy = 1 and enPC = enBF0 = enBF1 = 0 for exactly 3 cycles. Asserting brTaken during those cycles has no effect; RUN resumes on the 4th cycle.
- Branch vs load-use: brTaken = 1 in the same cycle as an LU condition -> flushBF0 = 1, bubbleBF1 = 1 and enPC = 1, with no stall. The next cycle's EXrec is cleared.
- Reset mid-op: assert rst_HC in the second MULTI cycle -> busy drops to 0 without waiting for a clock edge. fwdA = fwdB = 00. After release the pipeline runs, with enPC = 1 on the first cycle.

Source files
------------

// File: rtl/bf_hazard_ctrl.sv
// rtl/bf_hazard_ctrl.sv - stall/bubble/flush sequencing and operand forwarding for the BF0/BF1/MEM pipeline
module bf_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int RW      = 5
) (
    input  logic          clk_HC,
    input  logic          rst_HC,
    input  logic          idValid,
    input  logic [RW-1:0] idRs,
    input  logic [RW-1:0] idRt,
    input  logic          idUsesRs,
    input  logic          idUsesRt,
    input  logic [RW-1:0] idRd,
    input  logic          idRegWrite,
    input  logic          idMemRead,
    input  logic          idMulti,
    input  logic          brTaken,
    output logic          enPC,
    output logic          enBF0,
    output logic          enBF1,
    output logic          flushBF0,
    output logic          bubbleBF1,
    output logic [1:0]    fwdA,
    output logic [1:0]    fwdB,
    output logic          busy
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_MULTI = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    state_t        state_q;
    logic [3:0]    cnt_q;

    // Instruction currently in EX (loaded from BF1)
    logic          ex_valid_q;
    logic [RW-1:0] ex_rd_q;
    logic          ex_regwrite_q;
    logic          ex_memread_q;

    // Instruction currently in MEM
    logic          mem_valid_q;
    logic [RW-1:0] mem_rd_q;
    logic          mem_regwrite_q;

    logic [1:0]    fwd_a_q, fwd_a_d;
    logic [1:0]    fwd_b_q, fwd_b_d;

    logic          ex_match_rs, ex_match_rt;
    logic          mem_match_rs, mem_match_rt;
    logic          load_use;
    logic          take_multi;

    // A producer matches only if it really writes a non-zero register
    function automatic logic reg_match(
        input logic [RW-1:0] r,
        input logic          valid,
        input logic          regwrite,
        input logic [RW-1:0] rd
    );
        return valid && regwrite && (rd != '0) && (rd == r);
    endfunction

    // Dependency detection against the pre-edge stage records
    always_comb begin
        ex_match_rs  = idUsesRs && reg_match(idRs, ex_valid_q, ex_regwrite_q, ex_rd_q);
        ex_match_rt  = idUsesRt && reg_match(idRt, ex_valid_q, ex_regwrite_q, ex_rd_q);
        mem_match_rs = idUsesRs && reg_match(idRs, mem_valid_q, mem_regwrite_q, mem_rd_q);
        mem_match_rt = idUsesRt && reg_match(idRt, mem_valid_q, mem_regwrite_q, mem_rd_q);
        load_use     = idValid && ex_memread_q && (ex_match_rs || ex_match_rt);
        take_multi   = (state_q == S_RUN) && !rst_HC && !brTaken && !load_use
                       && idValid && idMulti;
    end

    // Pipeline enables in priority order: reset, multi-cycle freeze, branch, load-use
    always_comb begin
        enPC      = 1'b1;
        enBF0     = 1'b1;
        enBF1     = 1'b1;
        flushBF0  = 1'b0;
        bubbleBF1 = 1'b0;
        busy      = 1'b0;
        if (rst_HC) begin
            enPC      = 1'b0;
            enBF0     = 1'b0;
            enBF1     = 1'b0;
            flushBF0  = 1'b1;
            bubbleBF1 = 1'b1;
        end else if (state_q == S_MULTI) begin
            enPC  = 1'b0;
            enBF0 = 1'b0;
            enBF1 = 1'b0;
            busy  = 1'b1;
        end else if (brTaken) begin
            flushBF0  = 1'b1;
            bubbleBF1 = 1'b1;
        end else if (load_use) begin
            enPC      = 1'b0;
            enBF0     = 1'b0;
            bubbleBF1 = 1'b1;
        end
    end

    // Forwarding selects for the instruction about to enter BF1; EX beats MEM, loads in EX never forward
    always_comb begin
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if (ex_match_rs && !ex_memread_q) begin
            fwd_a_d = FWD_EX;
        end else if (mem_match_rs) begin
            fwd_a_d = FWD_MEM;
        end
        if (ex_match_rt && !ex_memread_q) begin
            fwd_b_d = FWD_EX;
        end else if (mem_match_rt) begin
            fwd_b_d = FWD_MEM;
        end
    end

    // Run / multi-cycle sequencer with latency down-counter
    always_ff @(posedge clk_HC or posedge rst_HC) begin
        if (rst_HC) begin
            state_q <= S_RUN;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (take_multi) begin
                        state_q <= S_MULTI;
                        cnt_q   <= CNT_INIT;
                    end
                end
                S_MULTI: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Stage records: advance with BF1, or hold EX and let a bubble drain into MEM
    always_ff @(posedge clk_HC or posedge rst_HC) begin
        if (rst_HC) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
        end else if (enBF1) begin
            mem_valid_q    <= ex_valid_q;
            mem_rd_q       <= ex_rd_q;
            mem_regwrite_q <= ex_regwrite_q;
            if (bubbleBF1) begin
                ex_valid_q    <= 1'b0;
                ex_rd_q       <= '0;
                ex_regwrite_q <= 1'b0;
                ex_memread_q  <= 1'b0;
            end else begin
                ex_valid_q    <= idValid;
                ex_rd_q       <= idRd;
                ex_regwrite_q <= idRegWrite;
                ex_memread_q  <= idMemRead;
            end
        end else begin
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
        end
    end

    // Forwarding selects travel with BF1: load on a real instruction, clear on a bubble, else hold
    always_ff @(posedge clk_HC or posedge rst_HC) begin
        if (rst_HC) begin
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else if (enBF1) begin
            if (bubbleBF1) begin
                fwd_a_q <= FWD_REG;
                fwd_b_q <= FWD_REG;
            end else begin
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
        end
    end

    assign fwdA = fwd_a_q;
    assign fwdB = fwd_b_q;

endmodule
